lsu_bus_bridge: RTL and testbench
=================================

Name: lsu_bus_bridge

Overview:
- Parametrised load/store bridge between the core memory stage and a single-port RAM/peripheral bus.
- Replaces the purely combinational byte-lane interface with a sequential, handshaked unit:
  - request/grant/response bus protocol;
  - configurable data width, with doubleword support at 64 bits;
  - byte-lane steering and sign/zero extension;
  - optional splitting of word-boundary-crossing accesses into two bus beats.
- Sits between the MEM stage and the RAM/bus arbiter.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, bus/data width in bits; legal values 32 or 64. BYTES = DATA_W/8 and OFF_W = log2(BYTES) are derived localparams.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  in  1  core access request; held until accepted.
- mem_ready  out  1  bridge idle, request accepted on mem_req&&mem_ready.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  ADDR_W  byte address.
- mem_size  in  2  log2 access bytes: 0=B, 1=H, 2=W, 3=D.
- mem_sign  in  1  1=zero-extend (unsigned load), 0=sign-extend.
- mem_wdata  in  DATA_W  store data, right-aligned.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_W  extended load data, valid with mem_done.
- mem_err  out  1  access rejected, valid with mem_done.
- bus_req  out  1  bus beat request.
- bus_gnt  in  1  beat accepted this cycle.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_W  BYTES-aligned beat address.
- bus_wen  out  BYTES  byte write strobes; all zero for reads.
- bus_wdata  out  DATA_W  lane-steered write data.
- bus_rvalid  in  1  beat response (read data or write ack).
- bus_rdata  in  DATA_W  read data.

Behaviour:
- Reset values:
  - state=IDLE, mem_ready=1.
  - mem_done=0, mem_err=0, mem_rdata=0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wen=0, bus_wdata=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- mem_ready=1 only in IDLE.
- On accept, all core inputs are latched; later changes to the core inputs have no effect.
- Decode of the latched request: off = addr[OFF_W-1:0], n = 1<<size, cross = (off+n > BYTES).
- Illegal if any of:
  - size=3 with DATA_W=32;
  - cross with split disabled.
- Illegal request: IDLE->RESP, no bus activity, mem_err=1, mem_rdata=0.
- IDLE->REQ0 on accept.
- REQ0:
  - bus_req=1, bus_addr = addr with low OFF_W bits cleared.
  - Strobes cover bytes off..min(off+n,BYTES)-1.
  - bus_wdata = wdata << 8*off, truncated.
  - Outputs stay stable until bus_gnt; on gnt -> WAIT0.
- WAIT0: bus_req=0; on bus_rvalid, capture bus_rdata. Then -> REQ1 if cross, else RESP.
- REQ1:
  - bus_addr = beat0 addr + BYTES, modulo 2^ADDR_W (wraps at top of address space).
  - Strobes cover bytes 0..off+n-BYTES-1.
  - bus_wdata = wdata >> 8*(BYTES-off).
  - On gnt -> WAIT1.
- WAIT1: on bus_rvalid, capture bus_rdata; -> RESP.
- RESP:
  - mem_done=1 for exactly one cycle, with registered mem_rdata/mem_err.
  - -> IDLE; next accept is possible the following cycle.
- Load data assembly:
  - Bytes off.. come from beat0; the remaining bytes come from beat1 bytes 0..
  - Result is right-aligned to n bytes.
  - Upper bits filled with (msb & ~mem_sign).
  - A full-width load is passed through unextended.
- Store responses: mem_rdata=0.
- Minimum aligned latency, with gnt in the first REQ cycle and rvalid one cycle later: accept edge T, bus_req T+1, rvalid T+2, mem_done T+3.
- Ignored bus inputs:
  - bus_gnt outside REQ0/REQ1.
  - bus_rvalid outside WAIT0/WAIT1, including a stale response arriving after reset.
- One beat outstanding at most.
- rvalid arriving in the same cycle as gnt is not a legal bus response; the bridge does not sample rvalid in REQ states.
- Reset mid-operation: immediate return to reset values. bus_req drops asynchronously and the request is lost; the core must reissue it.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses are executed as two beats (REQ0..WAIT1) as above.
- Undefined: REQ1/WAIT1 are not built. A crossing access is illegal and goes IDLE->RESP with mem_err=1 and no bus_req.

Test Plan:
- DATA_W=32, load B addr 0x1003, mem_sign=0, bus_rdata=0x80FF_FFFF -> bus_addr 0x1000, bus_wen 0000, mem_rdata 0xFFFF_FF80; with mem_sign=1 -> 0x0000_0080.
- Store H addr 0x2002, wdata 0x1234_ABCD -> one beat: bus_wen 1100, bus_wdata 0xABCD_0000, mem_done 3 cycles after accept with zero-wait gnt.
- Split defined, store W addr 0x3001, wdata 0xAABB_CCDD:
  - beat0: bus_addr 0x3000, wen 1110, wdata 0xBBCC_DD00;
  - beat1: bus_addr 0x3004, wen 0001, wdata 0x0000_00AA.
- Split defined, load H addr 0xFFFF_FFFF:
  - beat0 0xFFFF_FFFC, rdata 0x7F00_0000;
  - beat1 0x0000_0000 (wrap), rdata 0x0000_0001;
  - mem_rdata 0x0000_017F.
- bus_gnt held low for 5 cycles in REQ0 -> bus_req/addr/wen stable all 5 cycles. Stray bus_rvalid in IDLE -> no mem_done.
- Split undefined, load W addr 0x4002 -> mem_done with mem_err=1, bus_req never asserted. rst_n pulled low in WAIT0 -> bus_req=0, mem_ready=1 immediately.

Source files
------------

// File: rtl/lsu_bus_bridge_if.sv
// Interfaces for lsu_bus_bridge.
//   lsu_mem_if : core (MEM stage) side. The master modport is the core, the
//                slave modport is the bridge.
//   lsu_bus_if : RAM/peripheral bus side. The master modport is the bridge,
//                the slave modport is the RAM/arbiter.
// Handshake rules, both sides:
//   - A core request is accepted on a cycle where mem_req && mem_ready.
//   - mem_done is a one-cycle pulse. mem_rdata and mem_err are valid with it.
//   - A bus beat is accepted on a cycle where bus_req && bus_gnt. The bridge
//     holds bus_we, bus_addr, bus_wen and bus_wdata stable until then.
//   - bus_rvalid is only meaningful after the grant cycle, never in the same
//     cycle as it. At most one beat is outstanding.
interface lsu_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_size;
   logic              mem_sign;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_size, mem_sign, mem_wdata,
      input  mem_ready, mem_done, mem_rdata, mem_err
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_size, mem_sign, mem_wdata,
      output mem_ready, mem_done, mem_rdata, mem_err
   );
endinterface

interface lsu_bus_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  bus_req;
   logic                  bus_gnt;
   logic                  bus_we;
   logic [ADDR_W-1:0]     bus_addr;
   logic [DATA_W/8-1:0]   bus_wen;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_rvalid;
   logic [DATA_W-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wen, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );
   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wen, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: sequential load/store bridge between the MEM stage and a
// single-port RAM/peripheral bus. It does byte-lane steering and sign/zero
// extension.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   mem        : lsu_mem_if.slave, the core request/response side
//   bus        : lsu_bus_if.master, the request/grant/response bus side
//   dbg_state  : current FSM state, for observation
// Optional feature: define LSU_MISALIGN_SPLIT_EN to build the second-beat path
// (REQ1/WAIT1). An access that crosses a BYTES boundary then runs as two bus
// beats. Without the macro such an access completes with mem_err=1 and makes
// no bus request.
module lsu_bus_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   lsu_mem_if.slave   mem,
   lsu_bus_if.master  bus,
   output logic [2:0] dbg_state
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      RESP  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, sign_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   // Decode of the incoming request. It is used only to choose between REQ0
   // and RESP at accept time.
   logic [OFF_W-1:0]  in_off;
   logic [4:0]        in_end;
   logic              in_illegal;
   assign in_off     = mem.mem_addr[OFF_W-1:0];
   assign in_end     = 5'(in_off) + (5'd1 << mem.mem_size);
   assign in_illegal = ((DATA_W == 32) && (mem.mem_size == 2'd3)) ||
                       ((in_end > 5'(BYTES)) && !SPLIT_EN);

   // Decode of the latched request
   logic [OFF_W-1:0]  off_q;
   logic [4:0]        n_q, end_q;
   logic [OFF_W+2:0]  sh0;
   logic [ADDR_W-1:0] addr_al;
   logic [BYTES-1:0]  wen0;
   logic [DATA_W-1:0] wdata0;
   assign off_q   = addr_q[OFF_W-1:0];
   assign n_q     = 5'd1 << size_q;
   assign end_q   = 5'(off_q) + n_q;
   assign sh0     = {off_q, 3'b000};
   assign addr_al = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign wdata0  = wdata_q << sh0;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic              cross_q;
   logic [BYTES-1:0]  wen1;
   logic [DATA_W-1:0] wdata1, beat0_q, asm_lo;
   assign cross_q = end_q > 5'(BYTES);
   // Beat 1 carries the store bytes that did not fit above off in beat 0
   assign wdata1  = wdata_q >> (8 * (BYTES - int'(off_q)));
`endif

   always_comb begin
      wen0 = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      wen1 = '0;
`endif
      for (int i = 0; i < BYTES; i++) begin
         wen0[i] = we_q && (5'(i) >= 5'(off_q)) && (5'(i) < end_q);
`ifdef LSU_MISALIGN_SPLIT_EN
         wen1[i] = we_q && ((5'(i) + 5'(BYTES)) < end_q);
`endif
      end
   end

   // Load assembly. Shift the beat pair down by off so that the access starts
   // at byte 0. Bytes at and above n are then replaced with the fill bit.
   logic [DATA_W-1:0] asm_raw, load_data;
   logic              fill, load_done;
`ifdef LSU_MISALIGN_SPLIT_EN
   assign asm_lo    = (state_q == WAIT1) ? beat0_q : bus.bus_rdata;
   assign asm_raw   = DATA_W'({bus.bus_rdata, asm_lo} >> sh0);
   assign load_done = bus.bus_rvalid &&
                      (((state_q == WAIT0) && !cross_q) || (state_q == WAIT1));
`else
   assign asm_raw   = bus.bus_rdata >> sh0;
   assign load_done = bus.bus_rvalid && (state_q == WAIT0);
`endif

   always_comb begin
      fill = 1'b0;
      case (size_q)
         2'd0:    fill = asm_raw[7];
         2'd1:    fill = asm_raw[15];
         2'd2:    fill = asm_raw[31];
         default: fill = asm_raw[DATA_W-1];
      endcase
      fill      = fill & ~sign_q;
      load_data = '0;
      for (int i = 0; i < BYTES; i++) begin
         load_data[8*i +: 8] = (5'(i) < n_q) ? asm_raw[8*i +: 8] : {8{fill}};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (mem.mem_req)    state_d = in_illegal ? RESP : REQ0;
         REQ0:  if (bus.bus_gnt)    state_d = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
         WAIT0: if (bus.bus_rvalid) state_d = cross_q ? REQ1 : RESP;
         REQ1:  if (bus.bus_gnt)    state_d = WAIT1;
         WAIT1: if (bus.bus_rvalid) state_d = RESP;
`else
         WAIT0: if (bus.bus_rvalid) state_d = RESP;
`endif
         RESP:                      state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // The bus outputs are decoded from state. A reset therefore drops bus_req
   // as soon as rst_n falls, without waiting for a clock edge.
   always_comb begin
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wen   = '0;
      bus.bus_wdata = '0;
      case (state_q)
         REQ0: begin
            bus.bus_req   = 1'b1;
            bus.bus_we    = we_q;
            bus.bus_addr  = addr_al;
            bus.bus_wen   = wen0;
            bus.bus_wdata = wdata0;
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         REQ1: begin
            bus.bus_req   = 1'b1;
            bus.bus_we    = we_q;
            bus.bus_addr  = addr_al + ADDR_W'(BYTES);  // wraps at the top of the address space
            bus.bus_wen   = wen1;
            bus.bus_wdata = wdata1;
         end
`endif
         default: ;
      endcase
   end

   // Request latch and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         beat0_q <= '0;
`endif
      end else begin
         if ((state_q == IDLE) && mem.mem_req) begin
            we_q    <= mem.mem_we;
            sign_q  <= mem.mem_sign;
            addr_q  <= mem.mem_addr;
            size_q  <= mem.mem_size;
            wdata_q <= mem.mem_wdata;
            err_q   <= in_illegal;
            rdata_q <= '0;
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         if ((state_q == WAIT0) && bus.bus_rvalid) beat0_q <= bus.bus_rdata;
`endif
         if (load_done) rdata_q <= we_q ? '0 : load_data;
      end
   end

   assign mem.mem_ready = (state_q == IDLE);
   assign mem.mem_done  = (state_q == RESP);
   assign mem.mem_rdata = rdata_q;
   assign mem.mem_err   = err_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge with DATA_W=32. It drives core requests and
// acts as the bus slave, returning random read data. Every beat and every
// response is compared with a byte-level reference model. It builds with or
// without LSU_MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_lsu_bus_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if_i ();
  lsu_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if_i ();

  lsu_bus_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem(mem_if_i),
    .bus(bus_if_i),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic exp_err_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_illegal(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    int off, n;
    off = int'(addr % BYTES);
    n = 1 << size;
    return ((size == 2'd3) && (DATA_W == 32)) || ((off + n > BYTES) && !SPLIT);
  endfunction

  function automatic int model_beats(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    int off, n;
    off = int'(addr % BYTES);
    n = 1 << size;
    if (model_illegal(addr, size)) return 0;
    return (off + n > BYTES) ? 2 : 1;
  endfunction

  // Beat k of an access, built byte by byte. Store byte j goes to absolute
  // lane off+j across the two beats.
  task automatic model_beat(input int k, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [1:0] size, input logic [DATA_W-1:0] wdata,
                            output logic [ADDR_W-1:0] ea, output logic [BYTES-1:0] ew,
                            output logic [DATA_W-1:0] ed);
    int off, n, j;
    off = int'(addr % BYTES);
    n = 1 << size;
    ea = addr - ADDR_W'(off) + ADDR_W'(k * BYTES);
    ew = '0;
    ed = '0;
    for (int i = 0; i < BYTES; i++) begin
      j = i + k * BYTES - off;
      if (j >= 0 && j < BYTES) ed[8*i +: 8] = wdata[8*j +: 8];
      if (we && j >= 0 && j < n) ew[i] = 1'b1;
    end
  endtask

  function automatic logic [DATA_W-1:0] model_load(input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                                                   input logic sign, input logic [DATA_W-1:0] rd0,
                                                   input logic [DATA_W-1:0] rd1);
    int off, n, p;
    logic [63:0] val;
    logic [7:0] b;
    off = int'(addr % BYTES);
    n = 1 << size;
    val = '0;
    for (int j = 0; j < n; j++) begin
      p = off + j;
      b = (p < BYTES) ? rd0[8*p +: 8] : rd1[8*(p-BYTES) +: 8];
      val = val | (64'(b) << (8*j));
    end
    if (n < BYTES && !sign && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
    return val[DATA_W-1:0];
  endfunction

  // ---------------- driver / bus responder ----------------
  // gnt_wait >= 0: exact number of cycles without a grant, and rvalid comes
  // right after the grant. gnt_wait < 0: random waits plus stray bus inputs.
  task automatic run_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                            input logic sign, input logic [DATA_W-1:0] wdata, input int gnt_wait,
                            input bit force_rd, input logic [DATA_W-1:0] frd0,
                            input logic [DATA_W-1:0] frd1,
                            output int lat, output logic [DATA_W-1:0] got_rd, output logic got_err);
    int nb, cyc, t, d, d2;
    logic [ADDR_W-1:0] ea;
    logic [BYTES-1:0] ew;
    logic [DATA_W-1:0] ed;
    logic [DATA_W-1:0] rd [2];
    logic [DATA_W-1:0] exp_rd;
    logic exp_err;
    nb = model_beats(addr, size);
    rd[0] = force_rd ? frd0 : $urandom;
    rd[1] = force_rd ? frd1 : $urandom;
    if (model_illegal(addr, size)) begin
      exp_q.push_back('0);
      exp_err_q.push_back(1'b1);
    end else begin
      exp_q.push_back(we ? '0 : model_load(addr, size, sign, rd[0], rd[1]));
      exp_err_q.push_back(1'b0);
    end
    lat = -1;
    got_rd = '0;
    got_err = 1'b0;
    check_eq("ready_idle", 64'(mem_if_i.mem_ready), 64'd1);
    mem_if_i.mem_req = 1'b1;
    mem_if_i.mem_we = we;
    mem_if_i.mem_addr = addr;
    mem_if_i.mem_size = size;
    mem_if_i.mem_sign = sign;
    mem_if_i.mem_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    // Change the core inputs after accept. The bridge must ignore them.
    mem_if_i.mem_req = 1'b0;
    mem_if_i.mem_we = 1'($urandom);
    mem_if_i.mem_addr = $urandom;
    mem_if_i.mem_size = 2'($urandom);
    mem_if_i.mem_sign = 1'($urandom);
    mem_if_i.mem_wdata = $urandom;
    for (int k = 0; k < nb; k++) begin
      t = 0;
      while (!bus_if_i.bus_req && t < 8) begin
        @(negedge clk);
        cyc++;
        t++;
      end
      check_eq($sformatf("b%0d_req", k), 64'(bus_if_i.bus_req), 64'd1);
      model_beat(k, we, addr, size, wdata, ea, ew, ed);
      d = (gnt_wait >= 0) ? gnt_wait : $urandom_range(0, 3);
      for (int w = 0; w <= d; w++) begin
        check_eq($sformatf("b%0d_hold_req", k), 64'(bus_if_i.bus_req), 64'd1);
        check_eq($sformatf("b%0d_addr", k), 64'(bus_if_i.bus_addr), 64'(ea));
        check_eq($sformatf("b%0d_wen", k), 64'(bus_if_i.bus_wen), 64'(ew));
        check_eq($sformatf("b%0d_we", k), 64'(bus_if_i.bus_we), 64'(we));
        if (we) check_eq($sformatf("b%0d_wdata", k), 64'(bus_if_i.bus_wdata), 64'(ed));
        if (w < d) begin
          if (gnt_wait < 0) begin
            bus_if_i.bus_rvalid = 1'($urandom);
            bus_if_i.bus_rdata = $urandom;
          end
          @(negedge clk);
          cyc++;
          bus_if_i.bus_rvalid = 1'b0;
        end
      end
      bus_if_i.bus_gnt = 1'b1;
      @(negedge clk);
      cyc++;
      bus_if_i.bus_gnt = 1'b0;
      check_eq($sformatf("b%0d_req_drop", k), 64'(bus_if_i.bus_req), 64'd0);
      d2 = (gnt_wait >= 0) ? 0 : $urandom_range(0, 2);
      for (int w = 0; w < d2; w++) begin
        bus_if_i.bus_gnt = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
      bus_if_i.bus_gnt = 1'b0;
      bus_if_i.bus_rdata = rd[k];
      bus_if_i.bus_rvalid = 1'b1;
      @(negedge clk);
      cyc++;
      bus_if_i.bus_rvalid = 1'b0;
      bus_if_i.bus_rdata = $urandom;
    end
    t = 0;
    while (!mem_if_i.mem_done && t < 8) begin
      check_eq("no_extra_req", 64'(bus_if_i.bus_req), 64'd0);
      @(negedge clk);
      cyc++;
      t++;
    end
    check_eq("done_seen", 64'(mem_if_i.mem_done), 64'd1);
    check_eq("done_no_req", 64'(bus_if_i.bus_req), 64'd0);
    exp_rd = exp_q.pop_front();
    exp_err = exp_err_q.pop_front();
    check_eq("rdata", 64'(mem_if_i.mem_rdata), 64'(exp_rd));
    check_eq("err", 64'(mem_if_i.mem_err), 64'(exp_err));
    got_rd = mem_if_i.mem_rdata;
    got_err = mem_if_i.mem_err;
    lat = cyc;
    @(negedge clk);
    check_eq("done_pulse", 64'(mem_if_i.mem_done), 64'd0);
    check_eq("ready_after", 64'(mem_if_i.mem_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [DATA_W-1:0] rd;
    logic err;
    mem_if_i.mem_req = 1'b0;
    mem_if_i.mem_we = 1'b0;
    mem_if_i.mem_addr = '0;
    mem_if_i.mem_size = '0;
    mem_if_i.mem_sign = 1'b0;
    mem_if_i.mem_wdata = '0;
    bus_if_i.bus_gnt = 1'b0;
    bus_if_i.bus_rvalid = 1'b0;
    bus_if_i.bus_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(mem_if_i.mem_ready), 64'd1);
    check_eq("rst_done", 64'(mem_if_i.mem_done), 64'd0);
    check_eq("rst_err", 64'(mem_if_i.mem_err), 64'd0);
    check_eq("rst_rdata", 64'(mem_if_i.mem_rdata), 64'd0);
    check_eq("rst_bus_req", 64'(bus_if_i.bus_req), 64'd0);
    check_eq("rst_bus_we", 64'(bus_if_i.bus_we), 64'd0);
    check_eq("rst_bus_addr", 64'(bus_if_i.bus_addr), 64'd0);
    check_eq("rst_bus_wen", 64'(bus_if_i.bus_wen), 64'd0);
    check_eq("rst_bus_wdata", 64'(bus_if_i.bus_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte loads, sign- and zero-extended
    run_access(1'b0, 32'h0000_1003, 2'd0, 1'b0, '0, 0, 1'b1, 32'h80FF_FFFF, '0, lat, rd, err);
    check_eq("tp_ldb_sext", 64'(rd), 64'hFFFF_FF80);
    check_eq("tp_ldb_lat", 64'(lat), 64'd3);
    run_access(1'b0, 32'h0000_1003, 2'd0, 1'b1, '0, 0, 1'b1, 32'h80FF_FFFF, '0, lat, rd, err);
    check_eq("tp_ldb_zext", 64'(rd), 64'h0000_0080);

    // Halfword store, zero-wait
    run_access(1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h1234_ABCD, 0, 1'b0, '0, '0, lat, rd, err);
    check_eq("tp_sth_lat", 64'(lat), 64'd3);

    // Word-boundary-crossing store and load, including the address wrap
    run_access(1'b1, 32'h0000_3001, 2'd2, 1'b0, 32'hAABB_CCDD, 0, 1'b0, '0, '0, lat, rd, err);
    check_eq("tp_stw_cross_err", 64'(err), 64'(!SPLIT));
    run_access(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, '0, 0, 1'b1, 32'h7F00_0000, 32'h0000_0001, lat, rd, err);
    check_eq("tp_ldh_wrap", 64'(rd), SPLIT ? 64'h0000_017F : 64'h0);
    run_access(1'b0, 32'h0000_4002, 2'd2, 1'b0, '0, -1, 1'b0, '0, '0, lat, rd, err);
    check_eq("tp_ldw_cross_err", 64'(err), 64'(!SPLIT));
    if (!SPLIT) check_eq("tp_ldw_err_lat", 64'(lat), 64'd1);

    // A doubleword is illegal at 32 bits
    run_access(1'b0, 32'h0000_5000, 2'd3, 1'b0, '0, -1, 1'b0, '0, '0, lat, rd, err);
    check_eq("dword_err", 64'(err), 64'd1);

    // The grant is held off for 5 cycles. The beat must stay stable.
    run_access(1'b1, 32'h0000_6000, 2'd2, 1'b0, 32'hDEAD_BEEF, 5, 1'b0, '0, '0, lat, rd, err);
    check_eq("gnt_hold_lat", 64'(lat), 64'd8);

    // A stray rvalid in IDLE must not produce a response
    bus_if_i.bus_rvalid = 1'b1;
    bus_if_i.bus_rdata = $urandom;
    @(negedge clk);
    bus_if_i.bus_rvalid = 1'b0;
    repeat (3) begin
      check_eq("stray_no_done", 64'(mem_if_i.mem_done), 64'd0);
      check_eq("stray_ready", 64'(mem_if_i.mem_ready), 64'd1);
      @(negedge clk);
    end

    // Reset while REQ0 is waiting for the grant
    mem_if_i.mem_req = 1'b1;
    mem_if_i.mem_we = 1'b0;
    mem_if_i.mem_addr = 32'h0000_7000;
    mem_if_i.mem_size = 2'd2;
    @(posedge clk);
    @(negedge clk);
    mem_if_i.mem_req = 1'b0;
    check_eq("rst_req0_pre", 64'(bus_if_i.bus_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req0_drop", 64'(bus_if_i.bus_req), 64'd0);
    check_eq("rst_req0_ready", 64'(mem_if_i.mem_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in WAIT0, followed by a stale response
    mem_if_i.mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_if_i.mem_req = 1'b0;
    bus_if_i.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if_i.bus_gnt = 1'b0;
    check_eq("wait0_busy", 64'(mem_if_i.mem_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_wait0_ready", 64'(mem_if_i.mem_ready), 64'd1);
    check_eq("rst_wait0_req", 64'(bus_if_i.bus_req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if_i.bus_rvalid = 1'b1;
    bus_if_i.bus_rdata = $urandom;
    @(negedge clk);
    bus_if_i.bus_rvalid = 1'b0;
    repeat (3) begin
      check_eq("stale_no_done", 64'(mem_if_i.mem_done), 64'd0);
      @(negedge clk);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      run_access(1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                 -1, 1'b0, '0, '0, lat, rd, err);
    end

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
